stopwatch_timer_ctrl: RTL and testbench

//   Parametrised stopwatch/countdown-timer controller, successor to the fixed 2-button fsm.

---
 rtl/stopwatch_timer_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_stopwatch_timer_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stopwatch_timer_ctrl.sv
// Stopwatch / countdown-timer controller: mode FSM, saturating/wrapping time counter,
// running-only tick prescaler and a circular lap buffer read back oldest-first.
module stopwatch_timer_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TICK_DIV = 100
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pb0,
    input  logic                         pb1,
    output logic [WIDTH-1:0]             display,
    output logic [$clog2(DEPTH)-1:0]     lap_index,
    output logic [$clog2(DEPTH+1)-1:0]   lap_count,
    output logic [1:0]                   output_select,
    output logic                         running,
    output logic                         time_up
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = IW + 1;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_MODE_SELECT = 3'd0,
        S_SW_RUN      = 3'd1,
        S_SW_HOLD     = 3'd2,
        S_CYCLE       = 3'd3,
        S_TM_SET      = 3'd4,
        S_TM_RUN      = 3'd5,
        S_TIME_UP     = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_pb0_q;
    logic               r_pb1_q;
    logic [WIDTH-1:0]   r_count;
    logic [PW-1:0]      r_presc;
    logic [IW-1:0]      r_wr_ptr;
    logic [IW-1:0]      r_rd_idx;
    logic [CW-1:0]      r_lap_cnt;
    logic [WIDTH-1:0]   r_laps [DEPTH];

    logic               w_pb0_press;
    logic               w_pb1_press;
    logic               w_any_press;
    logic               w_running;
    logic               w_tick;
    logic               w_final_tick;
    logic               w_lap_we;
    logic [IW-1:0]      w_oldest;
    logic [SW-1:0]      w_phys_sum;
    logic [IW-1:0]      w_rd_addr;

    // pb0 has priority: a simultaneous pb1 edge is dropped
    assign w_pb0_press  = pb0 & ~r_pb0_q;
    assign w_pb1_press  = pb1 & ~r_pb1_q & ~w_pb0_press;
    assign w_any_press  = w_pb0_press | (pb1 & ~r_pb1_q);
    assign w_running    = (r_state == S_SW_RUN) || (r_state == S_TM_RUN);
    assign w_tick       = w_running && (r_presc == PW'(TICK_DIV - 1));
    assign w_final_tick = (r_state == S_TM_RUN) && w_tick && (r_count == WIDTH'(1));
    assign w_lap_we     = ~rst && (r_state == S_SW_RUN) && w_pb1_press;

    // Oldest entry sits at wr_ptr once the buffer has filled
    assign w_oldest   = (r_lap_cnt == CW'(DEPTH)) ? r_wr_ptr : '0;
    assign w_phys_sum = SW'(w_oldest) + SW'(r_rd_idx);
    assign w_rd_addr  = (w_phys_sum >= SW'(DEPTH)) ? IW'(w_phys_sum - SW'(DEPTH))
                                                   : IW'(w_phys_sum);

    assign lap_count = r_lap_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_MODE_SELECT;
            r_pb0_q <= 1'b0;
            r_pb1_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pb0_q <= pb0;
            r_pb1_q <= pb1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_MODE_SELECT: begin
                if (w_pb0_press)      w_state_nxt = S_SW_RUN;
                else if (w_pb1_press) w_state_nxt = S_TM_SET;
            end
            S_SW_RUN: begin
                if (w_pb0_press) w_state_nxt = S_SW_HOLD;
            end
            S_SW_HOLD: begin
                if (w_pb0_press)      w_state_nxt = (r_lap_cnt != '0) ? S_CYCLE : S_MODE_SELECT;
                else if (w_pb1_press) w_state_nxt = S_SW_RUN;
            end
            S_CYCLE: begin
                if (w_pb0_press) w_state_nxt = S_MODE_SELECT;
            end
            S_TM_SET: begin
                if (w_pb0_press && (r_count != '0)) w_state_nxt = S_TM_RUN;
            end
            S_TM_RUN: begin
                if (w_final_tick)     w_state_nxt = S_TIME_UP;
                else if (w_pb0_press) w_state_nxt = S_TM_SET;
            end
            S_TIME_UP: begin
                if (w_any_press) w_state_nxt = S_MODE_SELECT;
            end
            default: w_state_nxt = S_MODE_SELECT;
        endcase
    end

    always_comb begin
        output_select = 2'b00;
        running       = 1'b0;
        time_up       = 1'b0;
        lap_index     = '0;
        display       = r_count;
        case (r_state)
            S_SW_RUN:  begin output_select = 2'b01; running = 1'b1; end
            S_SW_HOLD: output_select = 2'b01;
            S_CYCLE: begin
                output_select = 2'b10;
                lap_index     = r_rd_idx;
                display       = r_laps[w_rd_addr];
            end
            S_TM_SET:  output_select = 2'b01;
            S_TM_RUN:  begin output_select = 2'b01; running = 1'b1; end
            S_TIME_UP: begin output_select = 2'b11; time_up = 1'b1; end
            default:   output_select = 2'b00;
        endcase
    end

    // Prescaler only advances while running
    always_ff @(posedge clk) begin
        if (rst || !w_running || w_tick) r_presc <= '0;
        else                             r_presc <= r_presc + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (w_lap_we) r_laps[r_wr_ptr] <= r_count;
    end

    // Entering or idling in MODE_SELECT always clears the session
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt == S_MODE_SELECT)) begin
            r_count   <= '0;
            r_wr_ptr  <= '0;
            r_rd_idx  <= '0;
            r_lap_cnt <= '0;
        end else begin
            case (r_state)
                S_SW_RUN: begin
                    if (w_tick && (r_count != '1)) r_count <= r_count + WIDTH'(1);
                    if (w_pb1_press) begin
                        r_wr_ptr <= (r_wr_ptr == IW'(DEPTH - 1)) ? '0 : r_wr_ptr + IW'(1);
                        if (r_lap_cnt != CW'(DEPTH)) r_lap_cnt <= r_lap_cnt + CW'(1);
                    end
                end
                S_SW_HOLD: begin
                    if (w_pb0_press) r_rd_idx <= '0;
                end
                S_CYCLE: begin
                    if (w_pb1_press)
                        r_rd_idx <= ((CW'(r_rd_idx) + CW'(1)) == r_lap_cnt) ? '0
                                                                           : r_rd_idx + IW'(1);
                end
                S_TM_SET: begin
                    if (w_pb1_press) r_count <= r_count + WIDTH'(1);
                end
                S_TM_RUN: begin
                    if (w_tick && (r_count != '0)) r_count <= r_count - WIDTH'(1);
                end
                S_TIME_UP: r_count <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Directed bench for stopwatch_timer_ctrl: DUT a (TICK_DIV=1) and DUT b (TICK_DIV=4),
// both WIDTH=4, DEPTH=3. Presses are one-cycle pulses followed by one released cycle.
module tb_stopwatch_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       a_pb0, a_pb1, b_pb0, b_pb1;
    logic [3:0] a_display, b_display;
    logic [1:0] a_idx, b_idx;
    logic [1:0] a_cnt, b_cnt;
    logic [1:0] a_sel, b_sel;
    logic       a_run, b_run, a_tu, b_tu;

    int errors = 0;
    int checks = 0;

    stopwatch_timer_ctrl #(.WIDTH(4), .DEPTH(3), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst(rst), .pb0(a_pb0), .pb1(a_pb1),
        .display(a_display), .lap_index(a_idx), .lap_count(a_cnt),
        .output_select(a_sel), .running(a_run), .time_up(a_tu)
    );

    stopwatch_timer_ctrl #(.WIDTH(4), .DEPTH(3), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .pb0(b_pb0), .pb1(b_pb1),
        .display(b_display), .lap_index(b_idx), .lap_count(b_cnt),
        .output_select(b_sel), .running(b_run), .time_up(b_tu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int disp, input int idx, input int cnt,
                         input int sel, input int run, input int tu);
        chk({tag, ".display"},   32'(a_display), 32'(disp));
        chk({tag, ".lap_index"}, 32'(a_idx),     32'(idx));
        chk({tag, ".lap_count"}, 32'(a_cnt),     32'(cnt));
        chk({tag, ".select"},    32'(a_sel),     32'(sel));
        chk({tag, ".running"},   32'(a_run),     32'(run));
        chk({tag, ".time_up"},   32'(a_tu),      32'(tu));
    endtask

    task automatic chk_b(input string tag, input int disp, input int idx, input int cnt,
                         input int sel, input int run, input int tu);
        chk({tag, ".display"},   32'(b_display), 32'(disp));
        chk({tag, ".lap_index"}, 32'(b_idx),     32'(idx));
        chk({tag, ".lap_count"}, 32'(b_cnt),     32'(cnt));
        chk({tag, ".select"},    32'(b_sel),     32'(sel));
        chk({tag, ".running"},   32'(b_run),     32'(run));
        chk({tag, ".time_up"},   32'(b_tu),      32'(tu));
    endtask

    // Called at a negedge; returns at a negedge two clock edges later
    task automatic press_a(input logic p0, input logic p1);
        a_pb0 = p0; a_pb1 = p1;
        @(negedge clk);
        a_pb0 = 1'b0; a_pb1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_b(input logic p0, input logic p1);
        b_pb0 = p0; b_pb1 = p1;
        @(negedge clk);
        b_pb0 = 1'b0; b_pb1 = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        a_pb0 = 1'b0; a_pb1 = 1'b0; b_pb0 = 1'b0; b_pb1 = 1'b0;
        idle(2);
        chk_a("reset_a", 0, 0, 0, 0, 0, 0);
        chk_b("reset_b", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // 1: stopwatch with two laps, hold, resume to saturation, cycle laps
        press_a(1, 0);  chk_a("t1_start", 1, 0, 0, 1, 1, 0);
        idle(4);        chk_a("t1_run5", 5, 0, 0, 1, 1, 0);
        press_a(0, 1);  chk_a("t1_lap1", 7, 0, 1, 1, 1, 0);
        press_a(0, 1);  chk_a("t1_lap2", 9, 0, 2, 1, 1, 0);
        press_a(1, 0);  chk_a("t1_hold", 10, 0, 2, 1, 0, 0);
        idle(2);        chk_a("t1_frozen", 10, 0, 2, 1, 0, 0);
        press_a(0, 1);  chk_a("t1_resume", 11, 0, 2, 1, 1, 0);
        idle(6);        chk_a("t1_sat", 15, 0, 2, 1, 1, 0);
        press_a(1, 0);  chk_a("t1_hold2", 15, 0, 2, 1, 0, 0);
        press_a(1, 0);  chk_a("t1_cyc0", 5, 0, 2, 2, 0, 0);
        press_a(0, 1);  chk_a("t1_cyc1", 7, 1, 2, 2, 0, 0);
        press_a(0, 1);  chk_a("t1_cyc_wrap", 5, 0, 2, 2, 0, 0);
        press_a(1, 0);  chk_a("t1_mode", 0, 0, 0, 0, 0, 0);

        // 2: four laps into a three-deep buffer, oldest overwritten
        press_a(1, 0);
        idle(1);        chk_a("t2_run", 2, 0, 0, 1, 1, 0);
        press_a(0, 1);
        press_a(0, 1);
        press_a(0, 1);
        press_a(0, 1);  chk_a("t2_laps", 10, 0, 3, 1, 1, 0);
        press_a(1, 0);  chk_a("t2_hold", 11, 0, 3, 1, 0, 0);
        press_a(1, 0);  chk_a("t2_cyc0", 4, 0, 3, 2, 0, 0);
        press_a(0, 1);  chk_a("t2_cyc1", 6, 1, 3, 2, 0, 0);
        press_a(0, 1);  chk_a("t2_cyc2", 8, 2, 3, 2, 0, 0);
        press_a(0, 1);  chk_a("t2_cyc_wrap", 4, 0, 3, 2, 0, 0);
        press_a(1, 0);  chk_a("t2_mode", 0, 0, 0, 0, 0, 0);

        // 3: countdown from 3 to time-up
        press_a(0, 1);  chk_a("t3_set", 0, 0, 0, 1, 0, 0);
        press_a(0, 1);
        press_a(0, 1);
        press_a(0, 1);  chk_a("t3_set3", 3, 0, 0, 1, 0, 0);
        press_a(1, 0);  chk_a("t3_run", 2, 0, 0, 1, 1, 0);
        idle(1);        chk_a("t3_run1", 1, 0, 0, 1, 1, 0);
        idle(1);        chk_a("t3_timeup", 0, 0, 0, 3, 0, 1);
        press_a(0, 1);  chk_a("t3_mode", 0, 0, 0, 0, 0, 0);

        // 4: zero start ignored, set counter wraps, final tick beats pb0
        press_a(0, 1);
        press_a(1, 0);  chk_a("t4_zero_start", 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) press_a(0, 1);
        chk_a("t4_set15", 15, 0, 0, 1, 0, 0);
        press_a(0, 1);  chk_a("t4_wrap", 0, 0, 0, 1, 0, 0);
        press_a(0, 1);
        press_a(0, 1);
        press_a(1, 0);  chk_a("t4_run", 1, 0, 0, 1, 1, 0);
        press_a(1, 0);  chk_a("t4_race", 0, 0, 0, 3, 0, 1);
        press_a(1, 0);  chk_a("t4_mode", 0, 0, 0, 0, 0, 0);

        // 5: TICK_DIV=4 prescaling, simultaneous buttons, hold with no laps
        press_b(1, 0);
        idle(2);        chk_b("t5_pre", 0, 0, 0, 1, 1, 0);
        idle(1);        chk_b("t5_tick1", 1, 0, 0, 1, 1, 0);
        idle(8);        chk_b("t5_count3", 3, 0, 0, 1, 1, 0);
        press_b(1, 1);  chk_b("t5_both", 3, 0, 0, 1, 0, 0);
        press_b(1, 0);  chk_b("t5_nolaps", 0, 0, 0, 0, 0, 0);

        // 6: synchronous reset mid countdown
        press_a(0, 1);
        for (int i = 0; i < 5; i++) press_a(0, 1);
        press_a(1, 0);  chk_a("t6_run", 4, 0, 0, 1, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_a("t6_reset", 0, 0, 0, 0, 0, 0);
        press_a(1, 0);  chk_a("t6_after", 1, 0, 0, 1, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
